// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor_pkg
//  Purpose  : Shared state encodings and sizing helper for the bit-serial
//             subtractor.
//  Revision : 1.0  initial release
// ============================================================================
package serial_subtractor_pkg;

   // Controller states (explicit 2-bit encoding)
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bit-counter width: enough to count 0..WIDTH-1, never narrower than 1 bit
   function automatic int cnt_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : full_subtractor
//  Purpose  : 1-bit full subtractor cell, d = a - b - bin, with borrow out.
//  Revision : 1.0  initial release
// ============================================================================
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic w_axb;

   // Difference bit and borrow out; borrow arises when b exceeds a, or they
   // are equal and a borrow is already pending.
   always_comb begin
      w_axb = a ^ b;
      d     = w_axb ^ bin;
      bout  = (~a & b) | (~w_axb & bin);
   end

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor
//  Purpose  : Bit-serial unsigned subtractor, diff = a - b, LSB first, one bit
//             per clock through a single full-subtractor cell.
//             start/busy/done handshake; results held until next start.
//  Revision : 1.0  initial release
// ============================================================================
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             zero
);

   localparam int                 c_CNT_W = cnt_width(WIDTH);
   // Exit compare is against WIDTH-1 so a power-of-two WIDTH never needs the
   // counter to reach WIDTH (which would not fit in c_CNT_W bits).
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

   state_t             r_state;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic               r_bin;
   logic [c_CNT_W-1:0] r_cnt;

   logic               w_d;
   logic               w_bout;
   logic               w_last;
   logic [WIDTH-1:0]   w_diff_next;

   // Single shared subtractor cell working on the current LSBs
   full_subtractor u_fs (
      .a    (r_a[0]),
      .b    (r_b[0]),
      .bin  (r_bin),
      .d    (w_d),
      .bout (w_bout)
   );

   // Next diff value with the new bit entering from the MSB side
   always_comb begin
      w_last      = (r_cnt == c_LAST);
      w_diff_next = {w_d, diff[WIDTH-1:1]};
   end

   // Controller and datapath: capture in IDLE, one bit per edge in RUN,
   // single-cycle done pulse in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_bin   <= 1'b0;
         r_cnt   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         diff    <= '0;
         borrow  <= 1'b0;
         zero    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_bin   <= 1'b0;
                  r_cnt   <= '0;
                  busy    <= 1'b1;
                  r_state <= RUN;
               end
            end
            RUN: begin
               diff  <= w_diff_next;
               r_a   <= {1'b0, r_a[WIDTH-1:1]};
               r_b   <= {1'b0, r_b[WIDTH-1:1]};
               r_bin <= w_bout;
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  borrow  <= w_bout;
                  zero    <= (w_diff_next == '0);
                  r_state <= DONE;
               end
            end
            DONE: begin
               done    <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_subtractor
//  Purpose  : Scoreboard bench for serial_subtractor and its full_subtractor
//             cell.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_subtractor;

   localparam int WIDTH = 8;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [WIDTH-1:0] a     = '0;
   logic [WIDTH-1:0] b     = '0;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic             zero;

   logic fa = 1'b0, fb = 1'b0, fbin = 1'b0;
   logic fd, fbout;

   int tests    = 0;
   int fails    = 0;
   int done_cnt = 0;

   // Expected results: {borrow, zero, diff}
   logic [WIDTH+1:0] exp_q[$];

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow),
      .zero   (zero)
   );

   full_subtractor fs_u (
      .a    (fa),
      .b    (fb),
      .bin  (fbin),
      .d    (fd),
      .bout (fbout)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model straight from the arithmetic definition
   function automatic logic [WIDTH+1:0] ref_model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      logic [WIDTH:0] t;
      t = {1'b0, x} - {1'b0, y};
      return {t[WIDTH], (t[WIDTH-1:0] == '0), t[WIDTH-1:0]};
   endfunction

   // Monitor: every done pulse pops and compares one expected result
   initial begin
      logic [WIDTH+1:0] e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_done: got done=1, expected no pending result");
            end else begin
               e = exp_q.pop_front();
               check("diff",   32'(diff),   32'(e[WIDTH-1:0]));
               check("zero",   32'(zero),   32'(e[WIDTH]));
               check("borrow", 32'(borrow), 32'(e[WIDTH+1]));
            end
         end
      end
   end

   // Drive a start request and wait for the accepting edge
   task automatic start_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                           input logic [WIDTH+1:0] e, input bit push);
      @(posedge clk);
      #1;
      start = 1'b1;
      a     = x;
      b     = y;
      if (push) exp_q.push_back(e);
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
      check("accept_busy", 32'(busy), 32'd1);
   endtask

   // Wait for done with a bound; n = negedges until done, nb = busy cycles
   task automatic wait_done(output int n, output int nb);
      n  = 0;
      nb = 0;
      for (int i = 0; i < 3 * WIDTH; i++) begin
         @(negedge clk);
         n++;
         if (busy) nb++;
         if (done) return;
      end
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done, expected done within %0d cycles", 3 * WIDTH);
   endtask

   initial begin
      int n, nb, dc;
      logic [WIDTH-1:0] x, y;

      // full_subtractor truth table against d - borrow arithmetic
      for (int i = 0; i < 8; i++) begin
         logic [1:0] t;
         {fa, fb, fbin} = 3'(i);
         #1;
         t = {1'b0, fa} - {1'b0, fb} - {1'b0, fbin};
         check("fs_d",    32'(fd),    32'(t[0]));
         check("fs_bout", 32'(fbout), 32'(t[1]));
      end

      // Reset state
      #2;
      check("rst_busy",   32'(busy),   32'd0);
      check("rst_done",   32'(done),   32'd0);
      check("rst_diff",   32'(diff),   32'd0);
      check("rst_borrow", 32'(borrow), 32'd0);
      check("rst_zero",   32'(zero),   32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Basic op, latency and busy length
      start_op(8'h5A, 8'h3C, {1'b0, 1'b0, 8'h1E}, 1'b1);
      wait_done(n, nb);
      check("latency",     32'(n),    32'(WIDTH + 1));
      check("busy_cycles", 32'(nb),   32'(WIDTH));
      check("busy_in_done", 32'(busy), 32'd0);
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
      check("hold_diff",      32'(diff), 32'h1E);

      // Borrow cases
      start_op(8'h00, 8'h01, {1'b1, 1'b0, 8'hFF}, 1'b1);
      wait_done(n, nb);
      start_op(8'h03, 8'hFF, {1'b1, 1'b0, 8'h04}, 1'b1);
      wait_done(n, nb);

      // Back-to-back with start held high
      @(posedge clk);
      #1;
      start = 1'b1;
      a = 8'h80;
      b = 8'h80;
      exp_q.push_back({1'b0, 1'b1, 8'h00});
      exp_q.push_back({1'b0, 1'b0, 8'hFF});
      @(posedge clk);
      #1;
      a = 8'hFF;
      b = 8'h00;
      wait_done(n, nb);
      @(posedge clk);
      @(posedge clk);
      #1;
      start = 1'b0;
      check("b2b_accept_busy", 32'(busy), 32'd1);
      wait_done(n, nb);

      // start mid-RUN with new operands is ignored
      dc = done_cnt;
      start_op(8'h5A, 8'h3C, {1'b0, 1'b0, 8'h1E}, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1;
      a = 8'h10;
      b = 8'h01;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(n, nb);
      repeat (12) @(posedge clk);
      check("ignored_start_done_count", 32'(done_cnt - dc), 32'd1);

      // Asynchronous reset mid-RUN
      dc = done_cnt;
      start_op(8'h5A, 8'h3C, '0, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      check("prerst_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_busy",   32'(busy),   32'd0);
      check("abort_done",   32'(done),   32'd0);
      check("abort_diff",   32'(diff),   32'd0);
      check("abort_borrow", 32'(borrow), 32'd0);
      check("abort_zero",   32'(zero),   32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (12) @(posedge clk);
      check("abort_no_done", 32'(done_cnt - dc), 32'd0);
      start_op(8'h5A, 8'h3C, {1'b0, 1'b0, 8'h1E}, 1'b1);
      wait_done(n, nb);

      // Random run against the reference model
      for (int i = 0; i < 1000; i++) begin
         x = WIDTH'($urandom);
         y = WIDTH'($urandom);
         start_op(x, y, ref_model(x, y), 1'b1);
         wait_done(n, nb);
      end

      repeat (3) @(posedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
